mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline.
- Consumes the outputs of the EX/MEM latch and drives the dcache request port (dmemREN/dmemWEN, dhit handshake).
- Resolves branches and jumps, holds the LL/SC link register, and produces the write-back payload for the MEM/WB latch.
- Stalls upstream latches while a data access is outstanding.

Parameters:
- MEMCTRL_W, 5, width of MEMctrl. Bit [0]=memread, [1]=memwrite, [2]=beq, [3]=bne, [4]=jump.
- WBCTRL_W, 4, width of WBctrl. Bit [0]=regwrite, [2]=link (write npc). Other bits pass through.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX/MEM entry holds a real (non-bubble) instruction.
- aluout  in  32  effective address / ALU result (word_t).
- store  in  32  store data.
- baddr  in  32  branch target.
- jaddr  in  32  jump target.
- npc  in  32  PC+4 of the instruction.
- zero  in  1  ALU zero flag.
- dest  in  5  destination register.
- MEMctrl  in  MEMCTRL_W  memory/branch control.
- WBctrl  in  WBCTRL_W  write-back control.
- datomic  in  1  LL when memread is set, SC when memwrite is set.
- ihit  in  1  pipeline advance strobe.
- dhit  in  1  dcache access complete.
- dmemload  in  32  dcache read data.
- snoop_inv  in  1  coherence invalidation valid.
- snoop_addr  in  32  invalidated address.
- dmemREN  out  1  dcache read request.
- dmemWEN  out  1  dcache write request.
- dmemaddr  out  32  dcache address.
- dmemstore  out  32  dcache write data.
- mem_stall  out  1  hold IF/ID, ID/EX, EX/MEM.
- redirect  out  1  PC redirect and younger-stage flush.
- redirect_addr  out  32  new PC.
- wb_valid  out  1  MEM/WB entry valid.
- wb_data  out  32  result to write back.
- wb_dest  out  5  passthrough of dest.
- wb_ctrl  out  WBCTRL_W  passthrough of WBctrl; bit [0] forced 0 on failed SC only if dest is unused (never: SC always writes its result).

Behaviour:
- Reset (nRST=0, async, any state including mid-access):
  - state=IDLE, link_valid=0, link_addr=0, result_q=0.
  - All outputs 0; dmemREN and dmemWEN drop in the same instant.
- memop = ex_valid & (MEMctrl[0] | MEMctrl[1]).
- sc_fail = memop & MEMctrl[1] & datomic & !(link_valid & link_addr==aluout).
- State IDLE:
  - memop & !sc_fail: mem_stall=1, go to WAIT next edge.
  - sc_fail: result_q=0, go to DONE. No dcache request, no stall cycle beyond the current one (mem_stall=1 in this cycle).
  - Otherwise (no memop): mem_stall=0.
- State WAIT:
  - dmemREN=MEMctrl[0], dmemWEN=MEMctrl[1], dmemaddr=aluout, dmemstore=store.
  - mem_stall=1.
  - On dhit: result_q = dmemload for a read, 1 for a successful SC; go to DONE.
  - Exactly one access per instruction, regardless of how many cycles dhit takes.
- State DONE:
  - Requests low, mem_stall=0.
  - On ihit: go to IDLE.
  - Without ihit: hold and do not re-issue the access.
- Link register:
  - LL dhit sets link_valid=1 and link_addr=aluout.
  - SC dhit (success) clears link_valid.
  - snoop_inv with snoop_addr==link_addr clears link_valid.
  - Snoop in the same cycle as an LL dhit to the same address: snoop wins, link_valid=0.
  - Any SC attempt, success or fail, clears link_valid.
- Branch/jump, combinational, gated by ex_valid:
  - taken = (MEMctrl[2]&zero) | (MEMctrl[3]&!zero).
  - redirect = taken | MEMctrl[4].
  - redirect_addr = MEMctrl[4] ? jaddr : baddr; otherwise 0.
- Write-back:
  - wb_data = WBctrl[2] ? npc : (memop ? result_q : aluout).
  - wb_valid = ex_valid & !mem_stall.
  - wb_dest, wb_ctrl are passthrough.
- Latency: a memory op occupies ≥2 cycles (IDLE→WAIT) plus dhit wait. A non-memory op has 0 extra cycles.

Decomposition:
- cpu_types_pkg gains:
  - memstate_t enum {IDLE, WAIT, DONE}.
  - Constants MEM_RD=0, MEM_WR=1, MEM_BEQ=2, MEM_BNE=3, MEM_JMP=4, WB_LINK=2.
  - word_t is reused.
- One sub-module: ll_sc_link. It holds link_valid/link_addr and implements the set, clear and snoop priority rules. It outputs link_match for a given address.

Test Plan:
- lw at aluout=0x100, dhit after 3 cycles with dmemload=0xDEADBEEF, then ihit → dmemREN high for exactly 3 cycles; mem_stall high 4 cycles; wb_data=0xDEADBEEF, wb_valid=1.
- sw addr 0x200, data 0x1234, dhit at 1st WAIT cycle → dmemWEN for one cycle, dmemstore=0x1234, dmemaddr=0x200, single access even if ihit is delayed 5 cycles.
- LL 0x300 then SC 0x300 → SC issues dmemWEN, wb_data=1, link_valid=0. Repeat with snoop_inv 0x300 between LL and SC → no dmemWEN, wb_data=0.
- beq with zero=1, baddr=0x40 → redirect=1, redirect_addr=0x40, same cycle. bne with zero=1 → redirect=0. Jump with jaddr=0x80 → redirect_addr=0x80.
- nRST pulsed low during WAIT of a lw → dmemREN drops immediately; after release: state IDLE, link_valid=0, all outputs 0.
- LL dhit and matching snoop_inv in the same cycle → link_valid=0; the following SC fails with wb_data=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, memory-stage FSM states and control-bit positions.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } memstate_t;

  // MEMctrl bit positions
  localparam int MEM_RD  = 0;
  localparam int MEM_WR  = 1;
  localparam int MEM_BEQ = 2;
  localparam int MEM_BNE = 3;
  localparam int MEM_JMP = 4;

  // WBctrl bit positions
  localparam int WB_LINK = 2;

endpackage

// File: rtl/ll_sc_link.sv
// LL/SC link register: remembers the last LL address until an SC, a matching
// snoop invalidation, or reset clears it.
module ll_sc_link
  import cpu_types_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_set,
  input  logic  i_clr,
  input  word_t i_addr,
  input  logic  i_snoop_inv,
  input  word_t i_snoop_addr,
  input  word_t i_cmp_addr,
  output logic  o_link_match
);

  logic  r_valid;
  word_t r_addr;
  logic  w_valid_next;
  word_t w_addr_next;

  always_comb begin
    w_valid_next = r_valid;
    w_addr_next  = r_addr;
    if (i_set) begin
      w_valid_next = 1'b1;
      w_addr_next  = i_addr;
    end
    if (i_clr) begin
      w_valid_next = 1'b0;
    end
    // Compare against the post-update address so a snoop racing an LL to the same line wins.
    if (i_snoop_inv && (i_snoop_addr == w_addr_next)) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_addr  <= w_addr_next;
    end
  end

  assign o_link_match = r_valid && (r_addr == i_cmp_addr);

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: dcache request sequencing, LL/SC, branch/jump
// resolution and the write-back payload for the MEM/WB latch.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned MEMCTRL_W = 5,
  parameter int unsigned WBCTRL_W  = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 ex_valid,
  input  word_t                aluout,
  input  word_t                store,
  input  word_t                baddr,
  input  word_t                jaddr,
  input  word_t                npc,
  input  logic                 zero,
  input  logic [4:0]           dest,
  input  logic [MEMCTRL_W-1:0] MEMctrl,
  input  logic [WBCTRL_W-1:0]  WBctrl,
  input  logic                 datomic,
  input  logic                 ihit,
  input  logic                 dhit,
  input  word_t                dmemload,
  input  logic                 snoop_inv,
  input  word_t                snoop_addr,
  output logic                 dmemREN,
  output logic                 dmemWEN,
  output word_t                dmemaddr,
  output word_t                dmemstore,
  output logic                 mem_stall,
  output logic                 redirect,
  output word_t                redirect_addr,
  output logic                 wb_valid,
  output word_t                wb_data,
  output logic [4:0]           wb_dest,
  output logic [WBCTRL_W-1:0]  wb_ctrl
);

  memstate_t r_state;
  memstate_t w_state_next;
  word_t     r_result;
  word_t     w_result_next;

  logic  w_memop;
  logic  w_sc_fail;
  logic  w_link_match;
  logic  w_ll_set;
  logic  w_sc_clr;
  logic  w_stall;
  logic  w_ren;
  logic  w_wen;
  word_t w_daddr;
  word_t w_dstore;
  logic  w_taken;
  logic  w_redirect;
  word_t w_redirect_addr;
  word_t w_wb_data;

  assign w_memop   = ex_valid & (MEMctrl[MEM_RD] | MEMctrl[MEM_WR]);
  assign w_sc_fail = w_memop & MEMctrl[MEM_WR] & datomic & ~w_link_match;

  ll_sc_link u_link (
    .i_clk        (CLK),
    .i_rst_n      (nRST),
    .i_set        (w_ll_set),
    .i_clr        (w_sc_clr),
    .i_addr       (aluout),
    .i_snoop_inv  (snoop_inv),
    .i_snoop_addr (snoop_addr),
    .i_cmp_addr   (aluout),
    .o_link_match (w_link_match)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_result <= w_result_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_result_next = r_result;
    w_stall       = 1'b0;
    w_ren         = 1'b0;
    w_wen         = 1'b0;
    w_daddr       = '0;
    w_dstore      = '0;
    w_ll_set      = 1'b0;
    w_sc_clr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_sc_fail) begin
          // Failed SC never reaches the cache; it completes with result 0.
          w_stall       = 1'b1;
          w_result_next = '0;
          w_sc_clr      = 1'b1;
          w_state_next  = DONE;
        end else if (w_memop) begin
          w_stall      = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        w_stall  = 1'b1;
        w_ren    = MEMctrl[MEM_RD];
        w_wen    = MEMctrl[MEM_WR];
        w_daddr  = aluout;
        w_dstore = store;
        if (dhit) begin
          w_state_next = DONE;
          if (MEMctrl[MEM_RD]) begin
            w_result_next = dmemload;
            w_ll_set      = datomic;
          end else if (datomic) begin
            w_result_next = 32'd1;
            w_sc_clr      = 1'b1;
          end
        end
      end
      DONE: begin
        if (ihit) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_taken    = (MEMctrl[MEM_BEQ] & zero) | (MEMctrl[MEM_BNE] & ~zero);
  assign w_redirect = ex_valid & (w_taken | MEMctrl[MEM_JMP]);

  always_comb begin
    w_redirect_addr = '0;
    if (w_redirect) begin
      w_redirect_addr = MEMctrl[MEM_JMP] ? jaddr : baddr;
    end
  end

  assign w_wb_data = WBctrl[WB_LINK] ? npc : (w_memop ? r_result : aluout);

  // Everything is forced low while reset is held, including pure passthroughs.
  assign dmemREN       = nRST & w_ren;
  assign dmemWEN       = nRST & w_wen;
  assign dmemaddr      = nRST ? w_daddr : '0;
  assign dmemstore     = nRST ? w_dstore : '0;
  assign mem_stall     = nRST & w_stall;
  assign redirect      = nRST & w_redirect;
  assign redirect_addr = nRST ? w_redirect_addr : '0;
  assign wb_valid      = nRST & ex_valid & ~w_stall;
  assign wb_data       = nRST ? w_wb_data : '0;
  assign wb_dest       = nRST ? dest : '0;
  assign wb_ctrl       = nRST ? WBctrl : '0;

endmodule
